alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle sequencer that computes the low 16 bits of a 16×16 unsigned product by driving the shared 16-bit ALU through a shift-add loop. It sits beside the ALU instance and drives its operand and control inputs itself, with no private adder. The CPU control unit starts it, stalls on `busy`, and takes the result when `done` pulses.

## Interface
- No parameters; datapath width fixed at 16.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a multiply. Sampled only when `busy`=0.
- `a` in 16: multiplicand, latched on accepted `start`.
- `b` in 16: multiplier, latched on accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle pulse; `product` is valid from that cycle onward.
- `product` out 16: low 16 bits of a·b; holds its value until the next accepted `start`.
- `alu_a` out 16: ALU operand a.
- `alu_b` out 16: ALU operand b.
- `alu_control` out 3: ALU opcode. 000 = add, 011 = shift left, 100 = shift right.
- `alu_result` in 16: ALU result, combinational, same cycle.
- `alu_zero` in 1: ALU zero flag, same cycle.

## Operation
- Internal registers:
  - `acc[15:0]`, `mcand[15:0]`, `mplier[15:0]`, `iter[3:0]`, state.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE:
  - ALU outputs are 0/0/000.
  - On `start` the block loads `acc`=0, `mcand`=a, `mplier`=b, `iter`=0.
  - Next state is DONE if b==0, else ADD.
- ADD:
  - Drives `alu_a`=acc, `alu_b`=(mplier[0] ? mcand : 0), `alu_control`=000.
  - Captures `acc`←`alu_result`.
  - Next state is SHL.
- SHL:
  - Drives `alu_a`=mcand, `alu_b`=1, `alu_control`=011.
  - Captures `mcand`←`alu_result`.
  - Next state is SHR.
- SHR:
  - Drives `alu_a`=mplier, `alu_b`=1, `alu_control`=100.
  - Captures `mplier`←`alu_result`; `iter`←iter+1.
  - Next state is DONE if the exit condition holds (see Configuration), else ADD.
- DONE:
  - `product`←acc, registered on entry so it is visible during DONE.
  - `done`=1; next state is IDLE.
- Arithmetic is modulo 2^16. Overflow bits are discarded with no flag. The low-half product is identical for two's-complement operands.
- `start` is ignored while `busy`=1 and during DONE. Operands are never relatched mid-operation.
- Reset from any state:
  - State returns to IDLE on the next edge.
  - `product`=0, `done`=0, `busy`=0.
  - ALU outputs are 0, 0, 000.
  - `acc`, `mcand`, `mplier` and `iter` are cleared to 0.
  - `reset` has priority over `start` in the same cycle.

## Timing
- Cycle 0 is the cycle in which `start` is accepted (edge E0 at its end).
- b==0: DONE occupies cycle 1; `done` and `busy` are high in cycle 1; `product`=0.
- b≠0 with N iterations: ADD/SHL/SHR repeat across cycles 1…3N; DONE is in cycle 3N+1.
- `busy` is high in cycles 1…3N+1.
- A new `start` can be accepted in cycle 3N+2, the first IDLE cycle.
- ALU outputs are combinational from state and registers. The ALU result is captured at the end of the same cycle, so there is one ALU op per cycle.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - SHR exits when `alu_zero`=1, i.e. the shifted multiplier is 0.
  - N = (index of highest set bit of b)+1, range 1…16.
- `MUL_EARLY_EXIT_EN` undefined:
  - SHR exits only when `iter`==15 before the increment, so N=16 always for b≠0 and latency is a fixed 49 cycles.
  - The b==0 shortcut to DONE is also removed: b==0 runs 16 iterations, with `product`=0 at cycle 49.

## Test plan
- a=3, b=5, early exit enabled → N=3; `done` in cycle 10; `product`=0x000F; ADD `alu_b` sequence is 3, 0, 12.
- a=0x1234, b=0 → `done` in cycle 1 (early exit enabled) or cycle 49 (disabled); `product`=0x0000.
- a=0xFFFF, b=0xFFFF → N=16; `done` in cycle 49; `product`=0x0001; `busy` high in cycles 1–49.
- a=7, b=9 accepted, then `start` with a=1, b=1 pulsed in cycle 4 → second request ignored; `product`=0x003F in cycle 13.
- a=0x00FF, b=0x0101 with `reset` asserted in cycle 5 → cycle 6 is IDLE with all outputs 0; a fresh `start` a=2, b=2 gives `product`=4 in cycle 7 after that start.
- Early exit disabled, a=3, b=5 → `done` in cycle 49; `product`=0x000F.

Source files
------------

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add 16x16 low-half multiply sequencer driving a shared ALU
//
// Computes product = (a * b) mod 2^16 by stepping the external ALU through
// ADD / SHL / SHR cycles. One ALU operation per clock; the ALU result is
// captured at the end of the cycle in which it is requested.
//
// Optional feature: define MUL_EARLY_EXIT_EN to end the loop as soon as the
// shifted multiplier reaches zero (and to skip the loop entirely for b == 0).
// Without it, every request runs 16 iterations (done in cycle 49).
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   start        in   request a multiply (sampled only while idle)
//   a, b         in   multiplicand / multiplier, latched on accepted start
//   busy         out  high from the cycle after an accepted start through done
//   done         out  one-cycle pulse, product valid from this cycle on
//   product      out  low 16 bits of a*b, held until the next result
//   alu_a        out  ALU operand a
//   alu_b        out  ALU operand b
//   alu_control  out  ALU opcode (000 add, 011 shift left, 100 shift right)
//   alu_result   in   ALU result, combinational
//   alu_zero     in   ALU zero flag, combinational
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_control,
  input  logic [15:0] alu_result,
  input  logic        alu_zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] product_q, product_d;
  logic [3:0]  iter_q, iter_d;
  logic        exit_shr;
  logic        zero_skip;

`ifdef MUL_EARLY_EXIT_EN
  // alu_zero reflects the freshly shifted multiplier during SHR. The iter
  // bound can never fire first (16 right shifts always reach zero) but keeps
  // the loop bounded by construction.
  assign exit_shr  = alu_zero || (iter_q == 4'd15);
  assign zero_skip = (b == 16'd0);
`else
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
  assign exit_shr  = (iter_q == 4'd15);
  assign zero_skip = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    iter_d      = iter_q;
    product_d   = product_q;
    alu_a       = 16'd0;
    alu_b       = 16'd0;
    alu_control = OP_ADD;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = 16'd0;
          mcand_d  = a;
          mplier_d = b;
          iter_d   = 4'd0;
          if (zero_skip) begin
            // acc is not yet cleared this cycle, so write the zero result directly.
            product_d = 16'd0;
            state_d   = S_DONE;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        alu_a       = acc_q;
        alu_b       = mplier_q[0] ? mcand_q : 16'd0;
        alu_control = OP_ADD;
        acc_d       = alu_result;
        state_d     = S_SHL;
      end
      S_SHL: begin
        alu_a       = mcand_q;
        alu_b       = 16'd1;
        alu_control = OP_SHL;
        mcand_d     = alu_result;
        state_d     = S_SHR;
      end
      S_SHR: begin
        alu_a       = mplier_q;
        alu_b       = 16'd1;
        alu_control = OP_SHR;
        mplier_d    = alu_result;
        iter_d      = iter_q + 4'd1;
        if (exit_shr) begin
          // acc already holds the final sum; register it on entry to DONE.
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= 16'd0;
      mcand_q   <= 16'd0;
      mplier_q  <= 16'd0;
      iter_q    <= 4'd0;
      product_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      iter_q    <= iter_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - randomized self-checking bench for alu_mul_seq with a behavioural ALU
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_control;
  logic [15:0] alu_result;
  logic        alu_zero;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  // Shared ALU stand-in.
  always_comb begin
    alu_result = 16'd0;
    case (alu_control)
      3'b000:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = alu_a << alu_b[3:0];
      3'b100:  alu_result = alu_a >> alu_b[3:0];
      default: alu_result = 16'd0;
    endcase
  end
  assign alu_zero = (alu_result == 16'd0);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operands.
  function automatic int n_iters(input logic [15:0] mb);
`ifdef MUL_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < 16; i++) if (mb[i]) msb = i;
    return msb + 1;
`else
    return (mb == 16'd0) ? 16 : 16;
`endif
  endfunction

  function automatic int exp_done_cycle(input logic [15:0] mb);
    return 3 * n_iters(mb) + 1;
  endfunction

  function automatic logic [15:0] exp_prod(input logic [15:0] ma, input logic [15:0] mb);
    logic [31:0] p;
    p = ma * mb;
    return p[15:0];
  endfunction

  function automatic logic [15:0] exp_add_operand(input logic [15:0] ma, input logic [15:0] mb,
                                                  input int i);
    logic [31:0] sh;
    sh = {16'd0, ma} << i;
    return ((mb >> i) & 16'd1) != 16'd0 ? sh[15:0] : 16'd0;
  endfunction

  // Called just after a negedge with the DUT idle. Issues a request and follows
  // it to completion; optionally pulses a competing start in cycle icyc.
  task automatic do_mul(input logic [15:0] ma, input logic [15:0] mb,
                        input int icyc, input logic [15:0] ia, input logic [15:0] ib);
    logic [15:0] adds[$];
    int cyc;
    bit seen;
    int n;
    logic [15:0] held;
    start = 1'b1;
    a = ma;
    b = mb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    cyc = 1;
    seen = 1'b0;
    while (cyc <= 60 && !seen) begin
      @(negedge clk);
      check_eq("busy_during_op", {31'd0, busy}, 32'd1);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (alu_control == 3'b000) adds.push_back(alu_b);
        if (cyc == icyc) begin
          start = 1'b1;
          a = ia;
          b = ib;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
      end
    end
    check_eq("done_cycle", seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_done_cycle(mb)));
    check_eq("product", {16'd0, product}, {16'd0, exp_prod(ma, mb)});
    n = n_iters(mb);
    check_eq("add_count", 32'(adds.size()), 32'(n));
    for (int i = 0; i < n && i < adds.size(); i++)
      check_eq("add_alu_b", {16'd0, adds[i]}, {16'd0, exp_add_operand(ma, mb, i)});
    held = exp_prod(ma, mb);
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_done", {31'd0, done}, 32'd0);
    check_eq("product_held", {16'd0, product}, {16'd0, held});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_product"}, {16'd0, product}, 32'd0);
    check_eq({tag, "_alu_a"}, {16'd0, alu_a}, 32'd0);
    check_eq({tag, "_alu_b"}, {16'd0, alu_b}, 32'd0);
    check_eq({tag, "_alu_ctl"}, {29'd0, alu_control}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    a = 16'd0;
    b = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    do_mul(16'd3, 16'd5, 0, 16'd0, 16'd0);
    do_mul(16'h1234, 16'd0, 0, 16'd0, 16'd0);
    do_mul(16'hFFFF, 16'hFFFF, 0, 16'd0, 16'd0);
    do_mul(16'd7, 16'd9, 4, 16'd1, 16'd1);

    // Reset mid-operation: asserted during cycle 5, cycle 6 must be idle.
    start = 1'b1;
    a = 16'h00FF;
    b = 16'h0101;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    do_mul(16'd2, 16'd2, 0, 16'd0, 16'd0);

    for (int k = 0; k < 20; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 16);
      if (k % 4 == 3) do_mul(ra, rb, 2, 16'($urandom), 16'($urandom));
      else            do_mul(ra, rb, 0, 16'd0, 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
